bp_update_ctrl: RTL and testbench

Controller that sequences the write side of the branch predictor (BHT and BTB) from resolved control-flow instructions in EX.
- Detects mispredictions and issues the one-cycle predict_fail pulse plus the redirect PC to fetch.
- Buffers resolved updates in a small FIFO.
- Drains the FIFO through a state machine that drives the predictor's BHT update, BTB invalidate and BTB update ports, one write per cycle.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/bp_upd_fifo.sv | 44 ++++
 rtl/bp_update_ctrl.sv | 147 ++++++++++++++
 tb/tb_bp_update_ctrl.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the branch-predictor update path.
package riscv_pkg;

   typedef enum logic [1:0] {
      BpNone = 2'b00,
      BpBr   = 2'b01,
      BpJal  = 2'b10,
      BpJalr = 2'b11
   } bp_type_e;

   typedef struct packed {
      bp_type_e    br_type;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic        inv;
   } bp_upd_entry_t;

   typedef enum logic [1:0] {
      StIdle,
      StBhtWr,
      StBtbInv,
      StBtbWr
   } bp_upd_state_e;

   function automatic logic [31:0] bp_fallthrough(input logic [31:0] pc, input logic rvc);
      return pc + (rvc ? 32'd2 : 32'd4);
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Circular update buffer; pointers carry an extra wrap bit to tell full from empty.
module bp_upd_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  bp_upd_entry_t wdata,
   input  logic          pop,
   output bp_upd_entry_t rdata,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]   wptr_q, rptr_q;
   bp_upd_entry_t mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty   = (wptr_q == rptr_q);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Payload storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// Detects mispredicts from EX and drains queued BHT/BTB writes, one write per cycle.
module bp_update_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             resolve_valid,
   output logic             resolve_ready,
   input  logic [1:0]       resolve_type,
   input  logic [31:0]      resolve_pc,
   input  logic             resolve_rvc,
   input  logic             resolve_taken,
   input  logic [31:0]      resolve_target,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   input  logic             ex_kill,
   input  logic             wr_stall,
   output logic             predict_fail,
   output logic [31:0]      redirect_pc,
   output logic             bht_updata,
   output logic [31:0]      bht_pc,
   output logic             bht_taken,
   output logic             btb_invalid,
   output logic             btb_update,
   output logic [31:0]      btb_pc,
   output logic [31:0]      btb_target,
   output logic [CNT_W-1:0] resolve_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam logic [CNT_W-1:0] CntOne = 1;

   bp_type_e      rtype;
   bp_upd_entry_t wentry, head;
   bp_upd_state_e state_q;
   logic          full, empty, acc, mis, push, pop, tgt_diff;

   assign rtype         = bp_type_e'(resolve_type);
   assign resolve_ready = ~full;
   assign acc           = resolve_valid & resolve_ready & ~ex_kill & (rtype != BpNone);
   assign tgt_diff      = (resolve_target != pred_target);

   always_comb begin
      mis = 1'b0;
      case (rtype)
         BpBr:    mis = (resolve_taken != pred_taken) | (resolve_taken & pred_taken & tgt_diff);
         BpJal:   mis = ~pred_taken;
         BpJalr:  mis = ~pred_taken | tgt_diff;
         default: mis = 1'b0;
      endcase
   end

   assign push = acc & ((rtype == BpBr) | ((rtype == BpJalr) & mis));
   assign pop  = (state_q == StBhtWr) | (state_q == StBtbWr);

   always_comb begin
      wentry         = '0;
      wentry.br_type = rtype;
      wentry.pc      = resolve_pc;
      wentry.taken   = resolve_taken;
      wentry.target  = resolve_target;
      wentry.inv     = pred_taken & tgt_diff;
   end

   bp_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (wentry),
      .pop     (pop),
      .rdata   (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         predict_fail   <= 1'b0;
         redirect_pc    <= '0;
         resolve_cnt    <= '0;
         mispredict_cnt <= '0;
      end else begin
         predict_fail <= acc & mis;
         redirect_pc  <= (acc & mis) ? (resolve_taken ? resolve_target :
                                        bp_fallthrough(resolve_pc, resolve_rvc)) : '0;
         if (acc && (resolve_cnt != '1))          resolve_cnt    <= resolve_cnt + CntOne;
         if (acc && mis && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CntOne;
      end
   end

   // Strobes and buses are registered alongside the state, so they track it exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         bht_updata  <= 1'b0;
         bht_pc      <= '0;
         bht_taken   <= 1'b0;
         btb_invalid <= 1'b0;
         btb_update  <= 1'b0;
         btb_pc      <= '0;
         btb_target  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (!empty && !wr_stall) begin
                  if (head.br_type == BpBr) begin
                     state_q    <= StBhtWr;
                     bht_updata <= 1'b1;
                     bht_pc     <= head.pc;
                     bht_taken  <= head.taken;
                  end else if (head.br_type == BpJalr) begin
                     state_q     <= head.inv ? StBtbInv : StBtbWr;
                     btb_invalid <= head.inv;
                     btb_update  <= ~head.inv;
                     btb_pc      <= head.pc;
                     btb_target  <= head.target;
                  end
               end
            end
            StBhtWr: begin
               state_q    <= StIdle;
               bht_updata <= 1'b0;
               bht_pc     <= '0;
               bht_taken  <= 1'b0;
            end
            StBtbInv: begin
               state_q     <= StBtbWr;
               btb_invalid <= 1'b0;
               btb_update  <= 1'b1;
            end
            StBtbWr: begin
               state_q    <= StIdle;
               btb_update <= 1'b0;
               btb_pc     <= '0;
               btb_target <= '0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: expected writes/redirects queued at drive, popped on output.
module tb_bp_update_ctrl;
   import riscv_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int          MAXCNT = 15;

   logic             clk, reset_n;
   logic             resolve_valid, resolve_ready, resolve_rvc, resolve_taken;
   logic [1:0]       resolve_type;
   logic [31:0]      resolve_pc, resolve_target, pred_target, redirect_pc;
   logic             pred_taken, ex_kill, wr_stall, predict_fail;
   logic             bht_updata, bht_taken, btb_invalid, btb_update;
   logic [31:0]      bht_pc, btb_pc, btb_target;
   logic [CNT_W-1:0] resolve_cnt, mispredict_cnt;

   bp_update_ctrl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .resolve_valid  (resolve_valid),
      .resolve_ready  (resolve_ready),
      .resolve_type   (resolve_type),
      .resolve_pc     (resolve_pc),
      .resolve_rvc    (resolve_rvc),
      .resolve_taken  (resolve_taken),
      .resolve_target (resolve_target),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_kill        (ex_kill),
      .wr_stall       (wr_stall),
      .predict_fail   (predict_fail),
      .redirect_pc    (redirect_pc),
      .bht_updata     (bht_updata),
      .bht_pc         (bht_pc),
      .bht_taken      (bht_taken),
      .btb_invalid    (btb_invalid),
      .btb_update     (btb_update),
      .btb_pc         (btb_pc),
      .btb_target     (btb_target),
      .resolve_cnt    (resolve_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 = BHT write, 1 = BTB invalidate, 2 = BTB write
   typedef struct {
      int          kind;
      logic [31:0] pc;
      logic [31:0] val;
   } wr_ev_t;

   wr_ev_t      wr_q[$];
   logic [31:0] pf_q[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_res = 0;
   int          exp_mis = 0;
   int          strobe_cnt = 0;
   int          cyc = 0;

   // Advance one clock and retire any DUT output against the scoreboard.
   task automatic step();
      wr_ev_t      e;
      int          kind;
      logic [31:0] pc, val, r;
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if ($countones({bht_updata, btb_invalid, btb_update}) > 1) begin
         errors++;
         $display("FAIL strobe_onehot: got %b, want at most one high",
                  {bht_updata, btb_invalid, btb_update});
      end
      if (bht_updata | btb_invalid | btb_update) begin
         strobe_cnt++;
         kind = bht_updata ? 0 : (btb_invalid ? 1 : 2);
         pc   = bht_updata ? bht_pc : btb_pc;
         val  = bht_updata ? {31'b0, bht_taken} : (btb_update ? btb_target : 32'h0);
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got kind=%0d pc=%h val=%h, want no write", kind, pc,
                     val);
         end else begin
            e = wr_q.pop_front();
            if (e.kind !== kind || e.pc !== pc || e.val !== val) begin
               errors++;
               $display("FAIL write_order: got kind=%0d pc=%h val=%h, want kind=%0d pc=%h val=%h",
                        kind, pc, val, e.kind, e.pc, e.val);
            end
         end
      end
      if (predict_fail) begin
         checks++;
         if (pf_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_predict_fail: got redirect=%h, want no pulse", redirect_pc);
         end else begin
            r = pf_q.pop_front();
            if (redirect_pc !== r) begin
               errors++;
               $display("FAIL redirect_pc: got %h, want %h", redirect_pc, r);
            end
         end
      end
   endtask

   task automatic offer(input bp_type_e t, input logic [31:0] pc, input logic rvc,
                        input logic taken, input logic [31:0] tgt, input logic pt,
                        input logic [31:0] ptgt, input logic kill, output logic acc);
      logic   m;
      wr_ev_t e;
      resolve_valid  = 1'b1;
      resolve_type   = t;
      resolve_pc     = pc;
      resolve_rvc    = rvc;
      resolve_taken  = taken;
      resolve_target = tgt;
      pred_taken     = pt;
      pred_target    = ptgt;
      ex_kill        = kill;
      acc = resolve_ready && !kill && (t != BpNone);
      if (acc) begin
         if (t == BpBr)        m = (taken != pt) || (taken && pt && tgt != ptgt);
         else if (t == BpJal)  m = !pt;
         else                  m = !pt || (tgt != ptgt);
         if (exp_res < MAXCNT) exp_res++;
         if (m && exp_mis < MAXCNT) exp_mis++;
         if (m) pf_q.push_back(taken ? tgt : pc + (rvc ? 32'd2 : 32'd4));
         if (t == BpBr) begin
            e.kind = 0; e.pc = pc; e.val = {31'b0, taken};
            wr_q.push_back(e);
         end else if (t == BpJalr && m) begin
            if (pt && tgt != ptgt) begin
               e.kind = 1; e.pc = pc; e.val = 32'h0;
               wr_q.push_back(e);
            end
            e.kind = 2; e.pc = pc; e.val = tgt;
            wr_q.push_back(e);
         end
      end
      step();
      resolve_valid = 1'b0;
      ex_kill       = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (wr_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      step();
      step();
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending writes, want 0", wr_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      resolve_valid = 1'b1;
      resolve_type  = BpBr;
      resolve_pc    = 32'h40;
      resolve_rvc   = 1'b0;
      resolve_taken = 1'b0;
      resolve_target = 32'h0;
      pred_taken    = 1'b0;
      pred_target   = 32'h0;
      ex_kill       = 1'b0;
      wr_stall      = 1'b0;
      repeat (3) step();
      checks++;
      if ({predict_fail, bht_updata, btb_invalid, btb_update} !== 4'b0 ||
          {redirect_pc, bht_pc, btb_pc, btb_target} !== 128'h0 || bht_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got strobes=%b buses nonzero, want all 0",
                  {predict_fail, bht_updata, btb_invalid, btb_update});
      end
      checks++;
      if (resolve_cnt !== '0 || mispredict_cnt !== '0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d, want 0/0", resolve_cnt, mispredict_cnt);
      end
      checks++;
      if (resolve_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, want 1", resolve_ready);
      end
      reset_n = 1'b1;
      exp_res = 1;
      wr_q.push_back('{kind: 0, pc: 32'h40, val: 32'h0});
      step();
      resolve_valid = 1'b0;
      checks++;
      if (bht_updata !== 1'b0) begin
         errors++;
         $display("FAIL reset_early_strobe: got %b, want 0", bht_updata);
      end
      step();
      checks++;
      if (bht_updata !== 1'b1 || bht_pc !== 32'h40) begin
         errors++;
         $display("FAIL reset_first_write: got %b pc=%h, want 1 pc=00000040", bht_updata, bht_pc);
      end
      drain();
   endtask

   task automatic test_br_mispredict();
      logic a;
      offer(BpBr, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, a);
      checks++;
      if (predict_fail !== 1'b1 || redirect_pc !== 32'h80) begin
         errors++;
         $display("FAIL br_pf: got %b redirect=%h, want 1 redirect=00000080", predict_fail,
                  redirect_pc);
      end
      step();
      checks++;
      if (bht_updata !== 1'b1 || bht_pc !== 32'h100 || bht_taken !== 1'b1) begin
         errors++;
         $display("FAIL br_bht: got %b pc=%h taken=%b, want 1 pc=00000100 taken=1", bht_updata,
                  bht_pc, bht_taken);
      end
      checks++;
      if (mispredict_cnt !== CNT_W'(exp_mis) || exp_mis != 1) begin
         errors++;
         $display("FAIL br_mis_cnt: got %0d, want 1", mispredict_cnt);
      end
      drain();
   endtask

   task automatic test_jalr();
      logic a;
      offer(BpJalr, 32'h200, 1'b1, 1'b1, 32'h400, 1'b1, 32'h300, 1'b0, a);
      checks++;
      if (predict_fail !== 1'b1 || redirect_pc !== 32'h400) begin
         errors++;
         $display("FAIL jalr_pf: got %b redirect=%h, want 1 redirect=00000400", predict_fail,
                  redirect_pc);
      end
      step();
      checks++;
      if (btb_invalid !== 1'b1 || btb_update !== 1'b0 || btb_pc !== 32'h200) begin
         errors++;
         $display("FAIL jalr_inv: got inv=%b upd=%b pc=%h, want inv=1 upd=0 pc=00000200",
                  btb_invalid, btb_update, btb_pc);
      end
      step();
      checks++;
      if (btb_update !== 1'b1 || btb_invalid !== 1'b0 || btb_pc !== 32'h200 ||
          btb_target !== 32'h400) begin
         errors++;
         $display("FAIL jalr_upd: got upd=%b pc=%h tgt=%h, want upd=1 pc=00000200 tgt=00000400",
                  btb_update, btb_pc, btb_target);
      end
      drain();
   endtask

   task automatic test_wrap();
      logic a;
      offer(BpBr, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, a);
      checks++;
      if (predict_fail !== 1'b0) begin
         errors++;
         $display("FAIL wrap_no_pf: got %b, want 0", predict_fail);
      end
      step();
      checks++;
      if (bht_updata !== 1'b1 || bht_taken !== 1'b0 || bht_pc !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL wrap_bht: got %b taken=%b pc=%h, want 1 taken=0 pc=fffffffe", bht_updata,
                  bht_taken, bht_pc);
      end
      step();
      offer(BpBr, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, a);
      checks++;
      if (predict_fail !== 1'b1 || redirect_pc !== 32'h0) begin
         errors++;
         $display("FAIL wrap_redirect: got %b redirect=%h, want 1 redirect=00000000",
                  predict_fail, redirect_pc);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic a, got5;
      int   acc_n, s0;
      int   stamps[$];
      wr_stall = 1'b1;
      acc_n    = 0;
      s0       = strobe_cnt;
      for (int i = 0; i < 5; i++) begin
         offer(BpBr, 32'h1000 + 32'(i * 4), 1'b0, i[0], 32'h2000, i[0], 32'h2000, 1'b0, a);
         if (a) acc_n++;
      end
      checks++;
      if (acc_n != 4 || resolve_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_fill: got accepts=%0d ready=%b, want accepts=4 ready=0", acc_n,
                  resolve_ready);
      end
      checks++;
      if (strobe_cnt != s0) begin
         errors++;
         $display("FAIL stall_no_write: got %0d writes, want 0", strobe_cnt - s0);
      end
      wr_stall = 1'b0;
      got5     = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (!got5) begin
            offer(BpBr, 32'h1010, 1'b0, 1'b0, 32'h2000, 1'b0, 32'h2000, 1'b0, a);
            got5 = a;
         end else begin
            step();
         end
         if (bht_updata) stamps.push_back(cyc);
      end
      checks++;
      if (!got5) begin
         errors++;
         $display("FAIL stall_fifth_accept: got 0, want 1");
      end
      checks++;
      if (stamps.size() != 5) begin
         errors++;
         $display("FAIL stall_write_count: got %0d, want 5", stamps.size());
      end else if (stamps[1] - stamps[0] != 2 || stamps[2] - stamps[1] != 2 ||
                   stamps[3] - stamps[2] != 2) begin
         errors++;
         $display("FAIL stall_spacing: got %0d,%0d,%0d, want 2,2,2", stamps[1] - stamps[0],
                  stamps[2] - stamps[1], stamps[3] - stamps[2]);
      end
      drain();
   endtask

   task automatic test_jal_kill();
      logic a;
      int   s0;
      s0 = strobe_cnt;
      offer(BpJal, 32'h300, 1'b0, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, a);
      checks++;
      if (predict_fail !== 1'b0) begin
         errors++;
         $display("FAIL jal_no_pf: got %b, want 0", predict_fail);
      end
      offer(BpBr, 32'h310, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, a);
      checks++;
      if (predict_fail !== 1'b0) begin
         errors++;
         $display("FAIL kill_no_pf: got %b, want 0", predict_fail);
      end
      checks++;
      if (resolve_cnt !== CNT_W'(exp_res)) begin
         errors++;
         $display("FAIL kill_resolve_cnt: got %0d, want %0d", resolve_cnt, exp_res);
      end
      repeat (4) step();
      checks++;
      if (strobe_cnt != s0) begin
         errors++;
         $display("FAIL jal_kill_no_write: got %0d writes, want 0", strobe_cnt - s0);
      end
   endtask

   task automatic test_reset_abort();
      logic a;
      offer(BpJalr, 32'h700, 1'b0, 1'b1, 32'h900, 1'b1, 32'h800, 1'b0, a);
      wr_q.pop_back();  // the BTB write is aborted by the reset below
      step();
      checks++;
      if (btb_invalid !== 1'b1) begin
         errors++;
         $display("FAIL abort_inv: got %b, want 1", btb_invalid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (btb_invalid !== 1'b0 || btb_update !== 1'b0 || btb_pc !== 32'h0) begin
         errors++;
         $display("FAIL abort_drop: got inv=%b upd=%b pc=%h, want 0 0 00000000", btb_invalid,
                  btb_update, btb_pc);
      end
      exp_res = 0;
      exp_mis = 0;
      step();
      step();
      reset_n = 1'b1;
      repeat (4) step();
      checks++;
      if (btb_update !== 1'b0 || wr_q.size() != 0 || resolve_cnt !== '0) begin
         errors++;
         $display("FAIL abort_after: got upd=%b pending=%0d cnt=%0d, want 0 0 0", btb_update,
                  wr_q.size(), resolve_cnt);
      end
      offer(BpBr, 32'hA00, 1'b0, 1'b1, 32'hB00, 1'b1, 32'hB00, 1'b0, a);
      drain();
   endtask

   task automatic test_saturate();
      logic a;
      int   tries;
      for (int i = 0; i < 20; i++) begin
         a     = 1'b0;
         tries = 0;
         while (!a && tries < 10) begin
            offer(BpBr, 32'h4000 + 32'(i * 4), 1'b0, 1'b1, 32'h5000 + 32'(i * 8), 1'b0, 32'h0,
                  1'b0, a);
            tries++;
         end
      end
      drain();
      checks++;
      if (resolve_cnt !== 4'hF || mispredict_cnt !== 4'hF) begin
         errors++;
         $display("FAIL saturate: got %0d/%0d, want 15/15", resolve_cnt, mispredict_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_br_mispredict();
      test_jalr();
      test_wrap();
      test_back_to_back();
      test_jal_kill();
      test_reset_abort();
      test_saturate();
      checks++;
      if (pf_q.size() != 0 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL final_queues: got pf=%0d wr=%0d pending, want 0 0", pf_q.size(),
                  wr_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
